vga_plot_capture: RTL and testbench

- Receiving end of the VGA plot interface (x, y, colour, plot) that the drawing blocks (fillscreen, circle, triangle) drive into the VGA adapter.
- Captures every plot into an internal 160x120x3 frame store and keeps accept/drop counters.
- Exposes a random-access read port and a raster-order dump stream with valid/ready handshake.
- Used as a synthesizable golden frame store for self-checking benches and on-board readback; sits beside vga_adapter on the same plot bus.

---
 rtl/vga_cap_pkg.sv | 24 ++
 rtl/vga_plot_capture_if.sv | 26 ++
 rtl/vga_cap_ram.sv | 23 ++
 rtl/vga_plot_capture.sv | 150 +++++++++++++++
 tb/tb_vga_plot_capture.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_cap_pkg.sv
// Shared geometry, state encoding and address helpers for the VGA plot capture store.
// Pure declarations: no latency, no backpressure.
package vga_cap_pkg;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_DUMP
  } state_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_plot_capture_if.sv
// Plot bus into the capture store plus its raster dump stream (valid/ready).
// Wires only: no latency; the dump side stalls while out_ready is low.
interface vga_plot_capture_if;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, out_ready,
    input  out_valid, out_x, out_y, out_colour
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, out_ready,
    output out_valid, out_x, out_y, out_colour
  );

endinterface

// File: rtl/vga_cap_ram.sv
// Simple dual-port frame RAM, one write and one read port, shaped for block-RAM inference.
// Read data registered one cycle after the address; a same-address write returns the old value; no backpressure.
module vga_cap_ram #(
  parameter int DEPTH = vga_cap_pkg::NPIX,
  parameter int AW    = vga_cap_pkg::ADDR_W,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_plot_capture.sv
// Golden frame store on the VGA plot bus: captures plots, counts accept/drop, serves random reads and a raster dump.
// Random read 1 cycle; dump valid 1 cycle after entering DUMP, holds under !out_ready, streams 1 px/cycle when ready.
module vga_plot_capture
  import vga_cap_pkg::*;
#(
  parameter int         WIDTH        = vga_cap_pkg::WIDTH,
  parameter int         HEIGHT       = vga_cap_pkg::HEIGHT,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_plot_capture_if.slave  bus,
  input  logic               clear_start,
  input  logic               dump_start,
  input  logic [7:0]         rd_x,
  input  logic [6:0]         rd_y,
  output logic [2:0]         rd_colour,
  output logic               busy,
  output logic               clear_done,
  output logic               dump_done,
  output logic [15:0]        plot_count,
  output logic [15:0]        drop_count
);

  localparam logic [7:0]        X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0]        Y_LAST = 7'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        fx;
  logic [6:0]        fy;
  logic              fetch_done;
  logic              rd_ok;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [2:0]        wdata;
  logic [2:0]        ram_q;

  logic plot_in_range, rd_in_range, advance, out_last;

  assign plot_in_range = (bus.vga_x <= X_LAST) && (bus.vga_y <= Y_LAST);
  assign rd_in_range   = (rd_x <= X_LAST) && (rd_y <= Y_LAST);
  assign advance       = !bus.out_valid || bus.out_ready;
  assign out_last      = (bus.out_x == X_LAST) && (bus.out_y == Y_LAST);

  assign busy       = (state != S_IDLE);
  assign clear_done = (state == S_CLEAR) && (clr_addr == A_LAST);
  assign dump_done  = (state == S_DUMP) && bus.out_valid && bus.out_ready && out_last;
  assign rd_colour  = rd_ok ? ram_q : 3'b000;
  assign bus.out_colour = bus.out_valid ? ram_q : 3'b000;

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = CLEAR_COLOUR;
    raddr = '0;
    case (state)
      S_CLEAR: we = 1'b1;
      S_IDLE: begin
        we    = bus.vga_plot && plot_in_range;
        waddr = pix_addr(bus.vga_x, bus.vga_y);
        wdata = bus.vga_colour;
        raddr = rd_in_range ? pix_addr(rd_x, rd_y) : '0;
      end
      // A stalled beat re-reads its own pixel so the registered RAM output stays put.
      S_DUMP:  raddr = advance ? pix_addr(fx, fy) : pix_addr(bus.out_x, bus.out_y);
      default: we = 1'b0;
    endcase
  end

  vga_cap_ram #(
    .DEPTH (WIDTH * HEIGHT),
    .AW    (ADDR_W),
    .DW    (3)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_CLEAR;
      clr_addr      <= '0;
      fx            <= '0;
      fy            <= '0;
      fetch_done    <= 1'b0;
      rd_ok         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      plot_count    <= '0;
      drop_count    <= '0;
    end else begin
      rd_ok <= (state == S_IDLE) && rd_in_range;
      case (state)
        S_CLEAR: begin
          if (bus.vga_plot) drop_count <= sat_inc(drop_count);
          if (clr_addr == A_LAST) state <= S_IDLE;
          else                    clr_addr <= clr_addr + 1'b1;
        end
        S_IDLE: begin
          if (clear_start) begin
            plot_count <= '0;
            drop_count <= '0;
            clr_addr   <= '0;
            state      <= S_CLEAR;
          end else begin
            if (bus.vga_plot && plot_in_range)  plot_count <= sat_inc(plot_count);
            if (bus.vga_plot && !plot_in_range) drop_count <= sat_inc(drop_count);
            if (dump_start) begin
              fx         <= '0;
              fy         <= '0;
              fetch_done <= 1'b0;
              state      <= S_DUMP;
            end
          end
        end
        S_DUMP: begin
          if (bus.vga_plot) drop_count <= sat_inc(drop_count);
          if (advance) begin
            if (!fetch_done) begin
              bus.out_x     <= fx;
              bus.out_y     <= fy;
              bus.out_valid <= 1'b1;
              if (fx == X_LAST) begin
                fx <= '0;
                fy <= fy + 1'b1;
                if (fy == Y_LAST) fetch_done <= 1'b1;
              end else begin
                fx <= fx + 1'b1;
              end
            end else begin
              bus.out_valid <= 1'b0;
              state         <= S_IDLE;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_capture.sv
// Directed bench for vga_plot_capture: reset clear, plots, drops, random reads, stalled dump, clear/dump priority, reset abort.
module tb_vga_plot_capture;
  import vga_cap_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_start, dump_start;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_colour;
  logic        busy, clear_done, dump_done;
  logic [15:0] plot_count, drop_count;

  vga_plot_capture_if bus ();

  vga_plot_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear_start (clear_start),
    .dump_start  (dump_start),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_colour   (rd_colour),
    .busy        (busy),
    .clear_done  (clear_done),
    .dump_done   (dump_done),
    .plot_count  (plot_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the registered read data.
  task automatic rd_pix(input logic [7:0] x, input logic [6:0] y, output logic [2:0] c);
    rd_x = x;
    rd_y = y;
    @(negedge clk);
    c = rd_colour;
  endtask

  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.vga_x      = x;
    bus.vga_y      = y;
    bus.vga_colour = c;
    bus.vga_plot   = 1'b1;
    @(negedge clk);
    bus.vga_plot   = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int cyc    = 0;
    int pulses = 0;
    int stray  = 0;
    int rd_nz  = 0;
    while (busy && cyc < 25000) begin
      cyc++;
      if (clear_done) pulses++;
      if (bus.out_valid || dump_done) stray++;
      if (rd_colour != 3'b000) rd_nz++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, cyc, NPIX);
    chk({tag, "_clear_done_pulses"}, pulses, 1);
    chk({tag, "_no_dump_activity"}, stray, 0);
    chk({tag, "_rd_zero_while_busy"}, rd_nz, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  function automatic logic [2:0] exp_col(input int n);
    if (n == 0)                    return 3'b001;
    if (n == 60 * WIDTH + 80)      return 3'b100;
    if (n == 10 * WIDTH + 10)      return 3'b101;
    if (n == NPIX - 1)             return 3'b111;
    return 3'b000;
  endfunction

  logic [2:0]  c, c_mid, c_last;
  logic [17:0] held;
  logic        stalled;
  int n, cyc, first_valid, dones, ord_err, col_err, stall_err, rd_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clear_start = 1'b0;
    dump_start  = 1'b0;
    rd_x = '0;
    rd_y = '0;
    bus.vga_x = '0;
    bus.vga_y = '0;
    bus.vga_colour = '0;
    bus.vga_plot  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_x", bus.out_x, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_out_colour", bus.out_colour, 0);
    chk("rst_rd_colour", rd_colour, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_dump_done", dump_done, 0);
    chk("rst_plot_count", plot_count, 0);
    chk("rst_drop_count", drop_count, 0);

    rst_n = 1'b1;
    wait_clear("init");
    rd_pix(8'd0, 7'd0, c);     chk("init_rd_0_0", c, 0);
    rd_pix(8'd159, 7'd119, c); chk("init_rd_159_119", c, 0);
    rd_pix(8'd80, 7'd60, c);   chk("init_rd_80_60", c, 0);

    plot(8'd0, 7'd0, 3'b001);
    plot(8'd159, 7'd119, 3'b111);
    plot(8'd80, 7'd60, 3'b100);
    chk("plot_count_3", plot_count, 3);
    chk("drop_count_0", drop_count, 0);
    rd_pix(8'd0, 7'd0, c);     chk("rd_0_0", c, 3'b001);
    rd_pix(8'd159, 7'd119, c); chk("rd_159_119", c, 3'b111);
    rd_pix(8'd80, 7'd60, c);   chk("rd_80_60", c, 3'b100);

    plot(8'd160, 7'd0, 3'b010);
    plot(8'd0, 7'd120, 3'b011);
    plot(8'd255, 7'd127, 3'b110);
    chk("drop_count_3", drop_count, 3);
    chk("plot_count_still_3", plot_count, 3);
    rd_pix(8'd0, 7'd0, c);     chk("rd_0_0_after_drops", c, 3'b001);
    rd_pix(8'd159, 7'd119, c); chk("rd_159_119_after_drops", c, 3'b111);
    rd_pix(8'd159, 7'd0, c);   chk("rd_159_0_untouched", c, 0);
    rd_pix(8'd255, 7'd127, c); chk("rd_out_of_range", c, 0);

    // Write and read the same address in one cycle: old data first, new data next.
    rd_x = 8'd10;
    rd_y = 7'd10;
    plot(8'd10, 7'd10, 3'b101);
    chk("rd_during_write_old", rd_colour, 0);
    @(negedge clk);
    chk("rd_after_write_new", rd_colour, 3'b101);
    chk("plot_count_4", plot_count, 4);

    // Full dump with random stalls.
    rd_x = 8'd0;
    rd_y = 7'd0;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    n = 0; cyc = 0; first_valid = -1; dones = 0;
    ord_err = 0; col_err = 0; stall_err = 0; rd_err = 0;
    stalled = 1'b0; held = '0; c_mid = 3'bxxx; c_last = 3'bxxx;
    while (cyc < 40000 && !(n == NPIX && !bus.out_valid)) begin
      bus.out_ready = ($urandom_range(7) != 0);
      #1;
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled && {bus.out_x, bus.out_y, bus.out_colour} != held) stall_err++;
        if (rd_colour != 3'b000) rd_err++;
        if (bus.out_ready) begin
          if (bus.out_x != 8'(n % WIDTH) || bus.out_y != 7'(n / WIDTH)) ord_err++;
          if (bus.out_colour != exp_col(n)) col_err++;
          if (n == 60 * WIDTH + 80) c_mid = bus.out_colour;
          if (n == NPIX - 1) c_last = bus.out_colour;
          n++;
        end
        stalled = !bus.out_ready;
        held = {bus.out_x, bus.out_y, bus.out_colour};
      end else begin
        stalled = 1'b0;
      end
      if (dump_done) dones++;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("dump_first_valid_in_range", (first_valid >= 1 && first_valid <= 2), 1);
    chk("dump_transfers", n, NPIX);
    chk("dump_raster_order_errors", ord_err, 0);
    chk("dump_colour_errors", col_err, 0);
    chk("dump_stall_hold_errors", stall_err, 0);
    chk("dump_rd_zero_errors", rd_err, 0);
    chk("dump_pixel_80_60", c_mid, 3'b100);
    chk("dump_pixel_last", c_last, 3'b111);
    chk("dump_done_pulses", dones, 1);
    chk("dump_valid_low_after", bus.out_valid, 0);
    chk("dump_busy_low_after", busy, 0);

    // Clear and dump together, with a plot in the same cycle: clear wins, plot not counted.
    rd_x = 8'd1;
    rd_y = 7'd1;
    clear_start = 1'b1;
    dump_start  = 1'b1;
    plot(8'd5, 7'd5, 3'b110);
    clear_start = 1'b0;
    dump_start  = 1'b0;
    chk("clr_busy", busy, 1);
    wait_clear("clr");
    chk("clr_plot_count", plot_count, 0);
    chk("clr_drop_count", drop_count, 0);
    rd_pix(8'd5, 7'd5, c);     chk("clr_rd_5_5", c, 0);
    rd_pix(8'd159, 7'd119, c); chk("clr_rd_159_119", c, 0);

    // Reset in the middle of a dump.
    plot(8'd80, 7'd60, 3'b100);
    rd_x = 8'd1;
    rd_y = 7'd1;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    bus.out_ready = 1'b1;
    n = 0; cyc = 0; dones = 0;
    while (n < 5000 && cyc < 10000) begin
      #1;
      if (bus.out_valid && bus.out_ready) n++;
      if (dump_done) dones++;
      if (n < 5000) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("abort_transfers", n, 5000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_dump_done", dump_done, 0);
    chk("abort_busy", busy, 1);
    chk("abort_plot_count", plot_count, 0);
    chk("abort_no_done_before", dones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("abort");
    rd_pix(8'd80, 7'd60, c);   chk("abort_rd_80_60", c, 0);
    rd_pix(8'd0, 7'd0, c);     chk("abort_rd_0_0", c, 0);
    rd_pix(8'd10, 7'd10, c);   chk("abort_rd_10_10", c, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
